// File: rtl/proc_feeder.sv
`default_nettype none
// ============================================================================
// Module   : proc_feeder
// Purpose  : Instruction sequencer for the 9-bit bus processor. Fetches
//            instruction words (and mvi immediates) from a synchronous-read
//            program ROM, presents them on DIN, strobes Run and waits for
//            Done before advancing. Provides start/stop control, a halt
//            opcode, a Done watchdog and a retired-instruction counter.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   AW         program address width (PC wraps modulo 2^AW)
//   TIMEOUT    WAIT cycles without Done before the watchdog fires
//   CW         width of the retired-instruction counter
// Ports
//   Clock      single clock, rising edge
//   Reset      synchronous, active-high
//   Start      begin execution at StartAddr (honoured in IDLE/HALT only)
//   StartAddr  first program address
//   Stop       return to IDLE once the current instruction retires
//   MemAddr    ROM address (data returns one cycle later on MemData)
//   MemData    ROM read data
//   DIN        registered word driven to the processor
//   Run        one-cycle issue strobe
//   Done       processor completion (sampled in WAIT only)
//   Busy       high in FETCH/DECODE/ISSUE/WAIT
//   Halted     sticky, set by halt opcode 111
//   Timeout    sticky, set when the watchdog expires
//   InstrCount retired instructions (wraps)
// ============================================================================
module proc_feeder #(
   parameter int AW      = 8,
   parameter int TIMEOUT = 16,
   parameter int CW      = 16
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          Start,
   input  logic [AW-1:0] StartAddr,
   input  logic          Stop,
   output logic [AW-1:0] MemAddr,
   input  logic [8:0]    MemData,
   output logic [8:0]    DIN,
   output logic          Run,
   input  logic          Done,
   output logic          Busy,
   output logic          Halted,
   output logic          Timeout,
   output logic [CW-1:0] InstrCount
);

   // Watchdog counts 0..TIMEOUT-1; the cycle in which it sits at
   // TIMEOUT-1 without Done is the TIMEOUT-th WAIT cycle.
   localparam int              WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);
   localparam logic [2:0]      OP_MVI  = 3'b001;
   localparam logic [2:0]      OP_HALT = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_ISSUE  = 3'd3,
      S_WAIT   = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [AW-1:0]   r_pc;
   logic [2:0]      r_op;
   logic [8:0]      r_din;
   logic            r_halted;
   logic            r_timeout;
   logic            r_stop_pend;
   logic [WDW-1:0]  r_wdog;
   logic [CW-1:0]   r_count;

   logic            w_start_acc;
   logic            w_halt_dec;
   logic            w_retire;
   logic            w_wd_expire;
   logic [AW-1:0]   w_mem_addr;
   logic            w_run;
   logic            w_busy;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and control decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_start_acc = 1'b0;
      w_halt_dec  = 1'b0;
      w_retire    = 1'b0;
      w_wd_expire = 1'b0;
      w_mem_addr  = r_pc;
      w_run       = 1'b0;
      w_busy      = 1'b0;

      case (r_state)
         S_IDLE, S_HALT: begin
            if (Start) begin
               w_start_acc = 1'b1;
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            w_busy      = 1'b1;
            w_state_nxt = S_DECODE;
         end
         S_DECODE: begin
            w_busy     = 1'b1;
            // Prefetch the following word so an mvi immediate is on
            // MemData during ISSUE.
            w_mem_addr = r_pc + 1'b1;
            if (MemData[8:6] == OP_HALT) begin
               w_halt_dec  = 1'b1;
               w_state_nxt = S_HALT;
            end else begin
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_busy      = 1'b1;
            w_run       = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            w_busy = 1'b1;
            // Done on the final watchdog cycle still retires the instruction.
            if (Done) begin
               w_retire    = 1'b1;
               w_state_nxt = (r_stop_pend || Stop) ? S_IDLE : S_FETCH;
            end else if (r_wdog == WD_LAST) begin
               w_wd_expire = 1'b1;
               w_state_nxt = S_HALT;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_pc        <= '0;
         r_op        <= '0;
         r_din       <= '0;
         r_halted    <= 1'b0;
         r_timeout   <= 1'b0;
         r_stop_pend <= 1'b0;
         r_wdog      <= '0;
         r_count     <= '0;
      end else begin
         if (w_start_acc) begin
            r_pc      <= StartAddr;
            r_halted  <= 1'b0;
            r_timeout <= 1'b0;
         end

         if (r_state == S_DECODE) begin
            r_op  <= MemData[8:6];
            r_din <= MemData;
            if (w_halt_dec) begin
               r_halted <= 1'b1;
               r_pc     <= r_pc + 1'b1;
            end
         end

         if (r_state == S_ISSUE) begin
            r_wdog <= '0;
            if (r_op == OP_MVI) begin
               // Immediate replaces the opcode word on DIN from the cycle
               // after Run; PC skips over it.
               r_din <= MemData;
               r_pc  <= r_pc + AW'(2);
            end else begin
               r_pc  <= r_pc + 1'b1;
            end
         end

         if ((r_state == S_WAIT) && !Done && !w_wd_expire) begin
            r_wdog <= r_wdog + 1'b1;
         end

         if (w_wd_expire) begin
            r_timeout <= 1'b1;
         end

         if (w_retire) begin
            r_count <= r_count + 1'b1;
         end

         // A Stop that arrives before a timeout leaves the pending flag set
         // in HALT; a fresh Start discards it so the new run is unaffected.
         if (w_start_acc || (w_retire && (w_state_nxt == S_IDLE))) begin
            r_stop_pend <= 1'b0;
         end else if (Stop && w_busy) begin
            r_stop_pend <= 1'b1;
         end
      end
   end

   assign MemAddr    = w_mem_addr;
   assign DIN        = r_din;
   assign Run        = w_run;
   assign Busy       = w_busy;
   assign Halted     = r_halted;
   assign Timeout    = r_timeout;
   assign InstrCount = r_count;

endmodule
`default_nettype wire

// File: tb/tb_proc_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_feeder
// Purpose  : Self-checking bench for proc_feeder. A program-walking model
//            queues the instructions each run should issue; a monitor pops
//            and compares on every Run strobe and checks DIN is held until
//            the instruction completes. Directed programs cover the
//            documented scenarios; random programs with random Done latency
//            and stray Start/Done activity cover the general case.
// Revision : 1.0  initial release
// ============================================================================
module tb_proc_feeder;

   localparam int AW      = 8;
   localparam int TIMEOUT = 16;
   localparam int CW      = 16;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          Start;
   logic [AW-1:0] StartAddr;
   logic          Stop;
   logic [AW-1:0] MemAddr;
   logic [8:0]    MemData;
   logic [8:0]    DIN;
   logic          Run;
   logic          Done = 1'b0;
   logic          Busy;
   logic          Halted;
   logic          Timeout;
   logic [CW-1:0] InstrCount;

   proc_feeder #(.AW(AW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Start      (Start),
      .StartAddr  (StartAddr),
      .Stop       (Stop),
      .MemAddr    (MemAddr),
      .MemData    (MemData),
      .DIN        (DIN),
      .Run        (Run),
      .Done       (Done),
      .Busy       (Busy),
      .Halted     (Halted),
      .Timeout    (Timeout),
      .InstrCount (InstrCount)
   );

   always #5 Clock = ~Clock;

   // Synchronous-read program ROM
   logic [8:0] rom [256];
   always @(posedge Clock) MemData <= rom[MemAddr];

   typedef struct {
      logic [8:0] word;
      bit         mvi;
      logic [8:0] imm;
   } exp_t;

   exp_t       exp_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   int         exp_cnt  = 0;
   bit         resp_en  = 1'b0;
   bit         resp_rand = 1'b0;
   int         stray_req = 0;
   logic [7:0] max_addr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic fail(input string name);
      n_checks++;
      $display("FAIL %s: event not seen", name);
   endtask

   // Walks the program the way the sequencer should: pushes one entry per
   // issued instruction, stops at a halt word or after max_instr issues.
   task automatic model_walk(input logic [7:0] start, input int max_instr,
                             output logic [7:0] end_pc, output int n);
      logic [7:0] pc;
      logic [7:0] nx;
      logic [8:0] w;
      exp_t       e;
      pc = start;
      n  = 0;
      while (n < max_instr) begin
         w = rom[pc];
         if (w[8:6] == 3'b111) begin
            pc = pc + 8'd1;
            break;
         end
         nx     = pc + 8'd1;
         e.word = w;
         e.mvi  = (w[8:6] == 3'b001);
         e.imm  = rom[nx];
         exp_q.push_back(e);
         pc = e.mvi ? (pc + 8'd2) : (pc + 8'd1);
         n++;
      end
      end_pc = pc;
   endtask

   task automatic build_random(input logic [7:0] start, input int n);
      logic [7:0] pc;
      logic [8:0] w;
      pc = start;
      for (int i = 0; i < n; i++) begin
         w      = 9'($urandom);
         w[8:6] = 3'($urandom_range(0, 6));
         rom[pc] = w;
         pc++;
         if (w[8:6] == 3'b001) begin
            rom[pc] = 9'($urandom);
            pc++;
         end
      end
      rom[pc] = 9'h1C0 | 9'($urandom_range(0, 63));
   endtask

   task automatic tick();
      @(negedge Clock);
      if (MemAddr > max_addr) max_addr = MemAddr;
   endtask

   // Issues Start; optionally pulses Stop so it is sampled in FETCH.
   // Returns at the negedge of the expected ISSUE cycle.
   task automatic start_prog(input logic [7:0] addr, input bit stop_fetch);
      tick();
      Start     = 1'b1;
      StartAddr = addr;
      @(posedge Clock);
      #1;
      Start = 1'b0;
      check("start_busy",        32'(Busy),    1);
      check("start_clr_halted",  32'(Halted),  0);
      check("start_clr_timeout", 32'(Timeout), 0);
      tick();
      Stop = stop_fetch;
      tick();
      Stop = 1'b0;
      check("decode_no_run", 32'(Run), 0);
      tick();
      check("run_latency", 32'(Run), 1);
   endtask

   task automatic wait_not_busy(input bit noise);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         tick();
         if (!Busy) begin
            seen = 1'b1;
            break;
         end
         if (noise) begin
            Start     = ($urandom_range(0, 3) == 0);
            StartAddr = 8'($urandom);
         end
      end
      Start = 1'b0;
      if (!seen) fail("wait_not_busy");
   endtask

   task automatic end_checks(input string tag, input bit exp_halt, input logic [7:0] end_pc);
      check({tag, "_busy"},    32'(Busy),       0);
      check({tag, "_halted"},  32'(Halted),     32'(exp_halt));
      check({tag, "_timeout"}, 32'(Timeout),    0);
      check({tag, "_count"},   32'(InstrCount), 32'(exp_cnt));
      check({tag, "_memaddr"}, 32'(MemAddr),    32'(end_pc));
      check({tag, "_drained"}, 32'(exp_q.size()), 0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_memaddr"}, 32'(MemAddr),    0);
      check({tag, "_din"},     32'(DIN),        0);
      check({tag, "_run"},     32'(Run),        0);
      check({tag, "_busy"},    32'(Busy),       0);
      check({tag, "_halted"},  32'(Halted),     0);
      check({tag, "_timeout"}, 32'(Timeout),    0);
      check({tag, "_count"},   32'(InstrCount), 0);
   endtask

   task automatic load_prog1();
      rom[0] = 9'b000_001_000;
      rom[1] = 9'b111_000_000;
   endtask

   // Processor stand-in: answers each Run with Done after 1..4 cycles and
   // sometimes holds Done one extra cycle (into FETCH/IDLE, where it must
   // be ignored). Also emits isolated Done pulses on request.
   initial begin : responder
      int stray_ack;
      int d;
      stray_ack = 0;
      forever begin
         @(negedge Clock);
         if (resp_en && Run) begin
            d = resp_rand ? $urandom_range(1, 4) : 1;
            repeat (d) @(negedge Clock);
            Done = 1'b1;
            @(negedge Clock);
            if (resp_rand && ($urandom_range(0, 1) == 1)) @(negedge Clock);
            Done = 1'b0;
         end else if (stray_req != stray_ack) begin
            Done = 1'b1;
            @(negedge Clock);
            Done = 1'b0;
            stray_ack++;
         end
      end
   end

   // Scoreboard monitor
   initial begin : monitor
      exp_t       e;
      logic [8:0] hold_val;
      bit         hold_active;
      hold_active = 1'b0;
      hold_val    = '0;
      forever begin
         @(negedge Clock);
         #1;
         if (Run) begin
            if (exp_q.size() == 0) begin
               fail("unexpected_run");
            end else begin
               e = exp_q.pop_front();
               check("issue_din", 32'(DIN), 32'(e.word));
               hold_val    = e.mvi ? e.imm : e.word;
               hold_active = 1'b1;
            end
         end else if (hold_active) begin
            check("din_hold", 32'(DIN), 32'(hold_val));
            if (Done || Reset || Timeout) hold_active = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin : main
      logic [7:0] end_pc;
      logic [7:0] s;
      int         n;
      for (int i = 0; i < 256; i++) rom[i] = '0;
      Reset     = 1'b1;
      Start     = 1'b0;
      Stop      = 1'b0;
      StartAddr = '0;
      max_addr  = '0;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      check_reset_values("rst");

      // mv then halt
      resp_en = 1'b1;
      load_prog1();
      max_addr = '0;
      model_walk(8'd0, 100, end_pc, n);
      start_prog(8'd0, 1'b0);
      wait_not_busy(1'b0);
      exp_cnt += n;
      end_checks("t1", 1'b1, end_pc);
      check("t1_max_addr", 32'(max_addr), 2);

      // mvi with immediate, then halt
      rom[4] = 9'b001_010_000;
      rom[5] = 9'h1A5;
      rom[6] = 9'b111_000_000;
      model_walk(8'd4, 100, end_pc, n);
      start_prog(8'd4, 1'b0);
      wait_not_busy(1'b0);
      exp_cnt += n;
      end_checks("t2", 1'b1, end_pc);

      // mvi at the top address wraps to address 0 for its immediate
      rom[255] = 9'b001_000_000;
      rom[0]   = 9'h0AA;
      rom[1]   = 9'b111_000_000;
      model_walk(8'd255, 100, end_pc, n);
      start_prog(8'd255, 1'b0);
      wait_not_busy(1'b0);
      exp_cnt += n;
      end_checks("t3", 1'b1, end_pc);

      // Watchdog: add never completes
      resp_en = 1'b0;
      rom[10] = 9'b010_000_000;
      rom[11] = 9'b111_000_000;
      model_walk(8'd10, 1, end_pc, n);
      start_prog(8'd10, 1'b0);
      repeat (TIMEOUT) tick();
      check("t4_timeout_early", 32'(Timeout), 0);
      check("t4_busy_early",    32'(Busy),    1);
      tick();
      check("t4_timeout",  32'(Timeout),    1);
      check("t4_busy",     32'(Busy),       0);
      check("t4_halted",   32'(Halted),     0);
      check("t4_count",    32'(InstrCount), 32'(exp_cnt));
      resp_en = 1'b1;
      load_prog1();
      model_walk(8'd0, 100, end_pc, n);
      start_prog(8'd0, 1'b0);
      wait_not_busy(1'b0);
      exp_cnt += n;
      end_checks("t4r", 1'b1, end_pc);

      // Stop during FETCH of a 3-instruction program
      rom[30] = 9'b000_001_000;
      rom[31] = 9'b011_001_000;
      rom[32] = 9'b010_000_000;
      rom[33] = 9'b111_000_000;
      model_walk(8'd30, 1, end_pc, n);
      start_prog(8'd30, 1'b1);
      wait_not_busy(1'b0);
      repeat (6) tick();
      exp_cnt += n;
      end_checks("t5", 1'b0, end_pc);

      // Reset in WAIT, stray Done afterwards, clean restart
      resp_en = 1'b0;
      rom[20] = 9'b010_000_000;
      rom[21] = 9'b111_000_000;
      model_walk(8'd20, 1, end_pc, n);
      start_prog(8'd20, 1'b0);
      tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check_reset_values("t6");
      exp_cnt = 0;
      stray_req++;
      repeat (4) tick();
      check("t6_done_ignored_busy",  32'(Busy),       0);
      check("t6_done_ignored_count", 32'(InstrCount), 0);
      resp_en = 1'b1;
      load_prog1();
      model_walk(8'd0, 100, end_pc, n);
      start_prog(8'd0, 1'b0);
      wait_not_busy(1'b0);
      exp_cnt += n;
      end_checks("t6r", 1'b1, end_pc);

      // Random programs, random Done latency, Start noise while busy
      resp_rand = 1'b1;
      for (int k = 0; k < 6; k++) begin
         s = 8'($urandom);
         build_random(s, $urandom_range(3, 8));
         model_walk(s, 100, end_pc, n);
         start_prog(s, 1'b0);
         wait_not_busy(1'b1);
         exp_cnt += n;
         end_checks("rnd", 1'b1, end_pc);
      end

      repeat (4) tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/proc_feeder.md
# proc_feeder

Instruction sequencer sitting directly upstream of the 9-bit bus processor. Fetches instruction words (and `mvi` immediates) from a synchronous-read program ROM, drives them on the processor's `DIN`, pulses `Run`, and waits for `Done` before advancing. It provides start/stop control, a halt opcode, a `Done` watchdog and a retired-instruction counter.

## Interface
- `AW`, 8, program address width; PC wraps modulo 2^AW
- `TIMEOUT`, 16, max cycles spent in WAIT without `Done` before error
- `CW`, 16, width of retired-instruction counter
- `Clock` in 1: single clock, all logic on rising edge
- `Reset` in 1: synchronous, active-high
- `Start` in 1: begin execution at `StartAddr`; honoured only in IDLE or HALT
- `StartAddr` in AW: first program address
- `Stop` in 1: request return to IDLE after the current instruction retires
- `MemAddr` out AW: ROM address; ROM data valid one cycle later
- `MemData` in 9: ROM read data
- `DIN` out 9: registered word to processor
- `Run` out 1: one-cycle issue strobe to processor
- `Done` in 1: processor completion, sampled only in WAIT
- `Busy` out 1: high in FETCH/DECODE/ISSUE/WAIT
- `Halted` out 1: sticky, set by halt opcode `111`
- `Timeout` out 1: sticky, set by watchdog expiry
- `InstrCount` out CW: instructions retired (wraps at 2^CW)

## Operation
- Opcode = word[8:6]: `000` mv, `001` mvi, `010` add, `011` sub, `111` halt (not issued); others are issued like `000`.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT, HALT.
- IDLE: `Start` -> PC<=StartAddr, clear `Halted`/`Timeout`, -> FETCH.
- FETCH: `MemAddr`=PC. -> DECODE.
- DECODE: MemData is the instruction; IR<=MemData, `DIN`<=MemData; `MemAddr`=PC+1 (prefetch immediate). Opcode `111` -> `Halted`<=1, PC<=PC+1, -> HALT. Otherwise -> ISSUE.
- ISSUE: `Run`=1 exactly this cycle, `DIN`=instruction. MemData holds word at PC+1. If mvi: `DIN`<=MemData, PC<=PC+2; else PC<=PC+1. Clear watchdog. -> WAIT.
- WAIT: `DIN` held. `Done`=1 -> `InstrCount`+1; if Stop pending -> IDLE, else -> FETCH. Watchdog increments each WAIT cycle without `Done`; reaching TIMEOUT -> `Timeout`<=1, -> HALT.
- Stop pending: latched when `Stop`=1 in any Busy state; cleared on entry to IDLE. `Stop` in IDLE/HALT is ignored.
- HALT: outputs frozen, `Run`=0; `Start` restarts as from IDLE.
- `Start` while Busy is ignored.
- PC arithmetic modulo 2^AW: mvi at address 2^AW-1 takes its immediate from address 0; next fetch is address 1.

## Timing
- Reset (sync): state IDLE, PC=0, `MemAddr`=0, `DIN`=0, `Run`=0, `Busy`=0, `Halted`=0, `Timeout`=0, `InstrCount`=0, Stop pending cleared. Reset mid-instruction abandons it; no `InstrCount` update.
- `Start` at edge t: FETCH in cycle t+1, DECODE t+2, ISSUE (`Run`=1) t+3.
- For mvi, `DIN` shows the immediate from cycle t+4 (cycle after `Run`) until retirement.
- `Done` in first WAIT cycle -> FETCH next cycle; minimum 4 cycles per instruction.
- `Done` and `Stop` in same WAIT cycle: instruction retires, then IDLE.
- `Done` outside WAIT is ignored.
- Watchdog: with no `Done`, `Timeout` rises exactly TIMEOUT cycles after entering WAIT; `Done` on that same cycle wins (retire, no timeout).

## Test plan
- ROM[0]=`000_001_000` (mv), ROM[1]=`111_000_000`; Start, StartAddr=0; `Done` one cycle after `Run` -> one `Run` pulse with `DIN`=0x008, `InstrCount`=1, `Halted`=1, `MemAddr` never issued past 2.
- ROM[4]=`001_010_000` (mvi), ROM[5]=0x1A5, ROM[6]=halt; StartAddr=4 -> `DIN`=0x050 during `Run`, 0x1A5 in next cycle and held until `Done`; next fetch address 6.
- mvi at address 255 (AW=8), ROM[0]=0x0AA -> immediate 0x0AA, next fetch at address 1.
- Issue add, never assert `Done` -> `Timeout`=1 exactly 16 cycles after WAIT entry, state HALT, `Busy`=0; Start clears `Timeout`.
- Stop asserted during FETCH of a 3-instruction program -> current instruction retires, IDLE, `InstrCount`=1, no further `Run`.
- Reset asserted in WAIT -> next cycle all outputs at reset values; `Done` afterwards ignored; Start restarts cleanly.
